lcd_ctrl_sequencer: RTL and testbench
=====================================

// Module: lcd_ctrl_sequencer
// PURPOSE
//  Sequences an HD44780-compatible character LCD on an 8-bit bus (write-only, RW tied low).
//  - Runs the power-on init sequence itself.
//  - Then accepts command/data bytes from one requester over a valid/ready handshake.
//  - Generates the RS/E timing and post-write wait for each byte.
//  Sits between message-generation logic (e.g. a HELLO text source) and the LCD pins.
// PARAMETERS
//  T_PWRUP  750000  cycles waited after reset before the first init command (15 ms @ 50 MHz)
//  T_EN     25      cycles lcd_enable is held high per write
//  T_CMD    2000    post-write wait for normal commands and data (40 us)
//  T_CLR    82000   post-write wait after clear (0x01) or home (0x02) with rs=0 (1.64 ms)
//  CNT_W    20      wait-counter width; must hold max(T_PWRUP, T_CLR)
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  req_valid   in   1  requester has a byte
//  req_rs      in   1  0 = command, 1 = character data
//  req_data    in   8  byte to write
//  req_ready   out  1  controller accepts a byte this cycle
//  init_done   out  1  init sequence complete, sticky until reset
//  busy        out  1  a write or wait is in progress (any state but IDLE)
//  lcd_data    out  8  LCD DB7..DB0
//  lcd_rs      out  1  LCD register select
//  lcd_rw      out  1  LCD read/write, constant 0
//  lcd_enable  out  1  LCD E strobe
// BEHAVIOUR
//  Reset values: all outputs 0, state PWRUP.
//  Reset mid-operation aborts the transfer immediately, drops E, and restarts from PWRUP.
//  States:
//   PWRUP: wait T_PWRUP cycles -> INIT.
//   INIT: issue 0x38, 0x0C, 0x01, 0x06 (rs=0) in order, each via SETUP/PULSE/WAIT.
//     After the last WAIT: init_done=1 -> IDLE.
//   IDLE: req_ready=1. Transfer on req_valid & req_ready: latch rs/data -> SETUP.
//   SETUP: 1 cycle. lcd_data/lcd_rs driven, E=0.
//   PULSE: E=1 for exactly T_EN cycles.
//   WAIT: E=0, T_CLR if (rs=0 & data in {0x01,0x02}), else T_CMD.
//     Then back to IDLE (or the next INIT step).
//  Timing and handshake:
//   Handshake-to-next-ready latency = 1 + T_EN + T_WAIT cycles.
//   lcd_data/lcd_rs are stable from SETUP through the end of WAIT.
//   req_ready is 0 in every non-IDLE state and during init.
//   req_valid is ignored while not ready, with no buffering; the requester must hold it.
//  Timer: down-counter loaded on state entry, state exits when it expires at count 1.
//   Cycle counts are exact, and a parameter value of 0 is treated as 1.
// CONFIGURATION
//  LCD_LINE_WRAP_EN defined:
//   - Tracks cursor line (0/1) and column (0..15), advanced on each data write.
//   - After a data write at col 15: auto-inserts command 0x80|0x40 (line 0 -> 1)
//     or 0x80 (line 1 -> 0), via SETUP/PULSE/WAIT(T_CMD), before req_ready returns.
//   - Command 0x01/0x02 clears line/col. Other commands leave line/col unchanged.
//  LCD_LINE_WRAP_EN undefined: no tracking, no inserted writes.
// STRUCTURE
//  Package lcd_pkg:
//   - state enum
//   - command constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, HOME 0x02,
//     ENTRY 0x06, DDRAM 0x80, LINE2 0x40)
//   - init ROM constant array
//  One sub-module: lcd_wait_timer (load value, count down, expire pulse).
// TESTING (sim params: T_PWRUP=10, T_EN=2, T_CMD=4, T_CLR=8)
//  Reset release -> E stays 0 for 10 cycles.
//   Then 4 E pulses carrying 0x38, 0x0C, 0x01, 0x06, each 2 cycles wide.
//   Gap after 0x01 is 8 cycles. Then init_done=1 and req_ready=1.
//  Write data 0x48 (H) -> lcd_rs=1, lcd_data=0x48, E high 2 cycles.
//   req_ready returns exactly 7 cycles after the handshake.
//  Command 0x01 -> wait 8 cycles, ready after 11. Command 0x01 with rs=1 -> 4-cycle wait.
//  Back-to-back HELLO with req_valid held high -> 5 pulses in order 48, 45, 4C, 4C, 4F.
//   No byte dropped or duplicated.
//  Assert reset mid-PULSE -> E=0, all outputs 0 same cycle, and init_done=0.
//   Full init sequence repeats after release.
//  LCD_LINE_WRAP_EN: write 16 chars -> extra pulse 0xC0 (rs=0) before ready.
//   Write 16 more -> 0x80 inserted. Without the macro: no inserted pulse.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD sequencer.
// Build option LCD_LINE_WRAP_EN (see lcd_ctrl_sequencer) uses wrap_cmd() from here.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] HOME     = 8'h02;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] DDRAM    = 8'h80;
    localparam logic [7:0] LINE2    = 8'h40;

    localparam int INIT_LEN = 4;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{FUNC_SET, DISP_ON, CLEAR, ENTRY};

    // Clear and home are the only writes that need the long post-write wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CLEAR) || (data == HOME));
    endfunction

    function automatic logic [7:0] wrap_cmd(input logic line);
        return DDRAM | (line ? LINE2 : 8'h00);
    endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter; expire_o is high during the last cycle of a loaded interval.
// A load value of 0 behaves as 1 so every interval lasts at least one cycle.
module lcd_wait_timer #(
    parameter int              CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_C = (RST_VAL == '0) ? ONE : RST_VAL;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_c;

    assign load_c   = (load_val_i == '0) ? ONE : load_val_i;
    assign expire_o = (cnt_q == ONE);

    // Count 0 means idle: no further expiry until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= RST_C;
        end else if (load_i) begin
            cnt_q <= load_c;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
        end
    end

endmodule

// File: rtl/lcd_ctrl_sequencer.sv
// HD44780 8-bit write-only sequencer: power-on init, then requester bytes with E/wait timing.
// Define LCD_LINE_WRAP_EN to track the cursor and auto-insert a DDRAM jump after column 15.
module lcd_ctrl_sequencer
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_EN    = 25,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_enable
);

    localparam logic [CNT_W-1:0] PWRUP_C = CNT_W'(T_PWRUP);
    localparam logic [CNT_W-1:0] SETUP_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] EN_C    = CNT_W'(T_EN);
    localparam logic [CNT_W-1:0] CMD_C   = CNT_W'(T_CMD);
    localparam logic [CNT_W-1:0] CLR_C   = CNT_W'(T_CLR);
    localparam logic [1:0]       LAST_IDX = 2'(INIT_LEN - 1);

    state_e           st_q, st_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             en_q, en_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;

`ifdef LCD_LINE_WRAP_EN
    logic             line_q, line_d;
    logic [3:0]       col_q, col_d;
    logic             wrap_pend_q, wrap_pend_d;
`endif

    lcd_wait_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (PWRUP_C)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // Handshake: a byte transfers on a rising clk edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and nothing is buffered while it is low.
    always_comb begin
        st_d        = st_q;
        rs_d        = rs_q;
        data_d      = data_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
`ifdef LCD_LINE_WRAP_EN
        line_d      = line_q;
        col_d       = col_q;
        wrap_pend_d = wrap_pend_q;
`endif
        case (st_q)
            ST_PWRUP: begin
                if (tmr_expire) begin
                    st_d     = ST_SETUP;
                    rs_d     = 1'b0;
                    data_d   = INIT_ROM[0];
                    idx_d    = 2'd0;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_C;
                end
            end
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    st_d     = ST_SETUP;
                    rs_d     = req_rs;
                    data_d   = req_data;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_C;
`ifdef LCD_LINE_WRAP_EN
                    if (req_rs) begin
                        if (col_q == 4'd15) begin
                            col_d       = 4'd0;
                            line_d      = ~line_q;
                            wrap_pend_d = 1'b1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else if (is_long_cmd(req_rs, req_data)) begin
                        line_d = 1'b0;
                        col_d  = 4'd0;
                    end
`endif
                end
            end
            ST_SETUP: begin
                if (tmr_expire) begin
                    st_d     = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = EN_C;
                end
            end
            ST_PULSE: begin
                if (tmr_expire) begin
                    st_d     = ST_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = is_long_cmd(rs_q, data_q) ? CLR_C : CMD_C;
                end
            end
            ST_WAIT: begin
                if (tmr_expire) begin
                    if (!init_done_q) begin
                        if (idx_q == LAST_IDX) begin
                            init_done_d = 1'b1;
                            st_d        = ST_IDLE;
                        end else begin
                            idx_d    = idx_q + 2'd1;
                            st_d     = ST_SETUP;
                            rs_d     = 1'b0;
                            data_d   = INIT_ROM[idx_q + 2'd1];
                            tmr_load = 1'b1;
                            tmr_val  = SETUP_C;
                        end
                    end else begin
                        st_d = ST_IDLE;
`ifdef LCD_LINE_WRAP_EN
                        // line_q already holds the line the cursor moved to.
                        if (wrap_pend_q) begin
                            st_d        = ST_SETUP;
                            rs_d        = 1'b0;
                            data_d      = wrap_cmd(line_q);
                            wrap_pend_d = 1'b0;
                            tmr_load    = 1'b1;
                            tmr_val     = SETUP_C;
                        end
`endif
                    end
                end
            end
            default: begin
                st_d = ST_PWRUP;
            end
        endcase

        ready_d = (st_d == ST_IDLE);
        busy_d  = (st_d != ST_IDLE);
        en_d    = (st_d == ST_PULSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= ST_PWRUP;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
            line_q      <= 1'b0;
            col_q       <= 4'd0;
            wrap_pend_q <= 1'b0;
`endif
        end else begin
            st_q        <= st_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            en_q        <= en_d;
`ifdef LCD_LINE_WRAP_EN
            line_q      <= line_d;
            col_q       <= col_d;
            wrap_pend_q <= wrap_pend_d;
`endif
        end
    end

    assign req_ready  = ready_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;
    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_enable = en_q;

endmodule

// File: tb/tb_lcd_ctrl_sequencer.sv
// Directed bench for lcd_ctrl_sequencer with short timing parameters.
// Honours LCD_LINE_WRAP_EN the same way as the design.
module tb_lcd_ctrl_sequencer;

    localparam int T_PWRUP = 10;
    localparam int T_EN    = 2;
    localparam int T_CMD   = 4;
    localparam int T_CLR   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy, lcd_rs, lcd_rw, lcd_enable;
    logic [7:0] lcd_data;

    lcd_ctrl_sequencer #(
        .T_PWRUP (T_PWRUP),
        .T_EN    (T_EN),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR),
        .CNT_W   (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rs     (req_rs),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .init_done  (init_done),
        .busy       (busy),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_enable (lcd_enable)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int mon_err = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         width;
        int         rise;
    } pulse_t;

    pulse_t     pulse_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] stream_buf [32];

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    // E-pulse monitor: records each pulse with its byte, width and rising cycle.
    initial begin
        logic   in_pulse;
        pulse_t cur;
        in_pulse = 1'b0;
        cur = '{1'b0, 8'h00, 0, 0};
        forever begin
            @(negedge clk);
            if (lcd_rw !== 1'b0) mon_err++;
            if (reset) begin
                in_pulse = 1'b0;
            end else if (lcd_enable === 1'b1) begin
                if (!in_pulse) begin
                    in_pulse  = 1'b1;
                    cur.rs    = lcd_rs;
                    cur.data  = lcd_data;
                    cur.width = 1;
                    cur.rise  = cyc;
                end else begin
                    cur.width++;
                    if (lcd_rs !== cur.rs || lcd_data !== cur.data) mon_err++;
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                pulse_q.push_back(cur);
            end
        end
    end

    // ---------------- checking tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: req_ready still low after %0d cycles", name, budget);
        end
    endtask

    task automatic chk_pulse(input string name, input logic [8:0] exp_b);
        pulse_t p;
        if (pulse_q.size() == 0) begin
            chk({name, "_present"}, 32'd0, 32'd1);
        end else begin
            p = pulse_q.pop_front();
            chk({name, "_byte"}, {23'd0, p.rs, p.data}, {23'd0, exp_b});
            chk({name, "_width"}, p.width, T_EN);
        end
    endtask

    task automatic chk_stream(input string name);
        chk({name, "_count"}, pulse_q.size(), exp_q.size());
        while (exp_q.size() != 0) chk_pulse(name, exp_q.pop_front());
        pulse_q.delete();
    endtask

    // Releases reset and checks the complete power-on init sequence.
    task automatic do_init(input string name);
        int         t0, n, viol;
        pulse_t     p;
        logic [8:0] ib [4];
        int         ir [4];
        ib[0] = 9'h038; ib[1] = 9'h00C; ib[2] = 9'h001; ib[3] = 9'h006;
        ir[0] = 11;     ir[1] = 18;     ir[2] = 25;     ir[3] = 36;
        pulse_q.delete();
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        n = 0;
        viol = 0;
        while (init_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (init_done !== 1'b1 && req_ready !== 1'b0) viol++;
        end
        chk({name, "_done_cycle"}, cyc - t0, 42);
        chk({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({name, "_ready_low_during"}, viol, 0);
        chk({name, "_pulses"}, pulse_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (pulse_q.size() != 0) begin
                p = pulse_q.pop_front();
                chk({name, "_byte"}, {23'd0, p.rs, p.data}, {23'd0, ib[i]});
                chk({name, "_width"}, p.width, T_EN);
                chk({name, "_rise"}, p.rise - t0, ir[i]);
            end
        end
        pulse_q.delete();
    endtask

    task automatic send_stream(input int n, input string name, output int last_lat);
        int c0;
        c0 = cyc;
        req_rs    = 1'b1;
        req_data  = stream_buf[0];
        req_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_ready(name, 100);
            c0 = cyc;
            @(posedge clk);
            @(negedge clk);
            if (i + 1 < n) req_data = stream_buf[i + 1];
            else req_valid = 1'b0;
        end
        wait_ready(name, 100);
        last_lat = cyc - (c0 + 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0, lat, n;

        vecs[0] = '{1'b1, 8'h48, 7};
        vecs[1] = '{1'b0, 8'h01, 11};
        vecs[2] = '{1'b1, 8'h01, 7};
        vecs[3] = '{1'b0, 8'h02, 11};
        vecs[4] = '{1'b0, 8'h38, 7};
        vecs[5] = '{1'b1, 8'h02, 7};
        vecs[6] = '{1'b0, 8'h80, 7};
        vecs[7] = '{1'b0, 8'h03, 7};

        repeat (3) @(negedge clk);
        chk("rst_enable", {31'd0, lcd_enable}, 32'd0);
        chk("rst_data", {24'd0, lcd_data}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);

        do_init("init");

        // Single writes: latency from handshake edge to req_ready.
        for (int i = 0; i < 8; i++) begin
            wait_ready("vec", 100);
            req_valid = 1'b1;
            req_rs    = vecs[i].rs;
            req_data  = vecs[i].data;
            c0 = cyc;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            chk("vec_ready_drop", {31'd0, req_ready}, 32'd0);
            chk("vec_busy", {31'd0, busy}, 32'd1);
            wait_ready("vec", 100);
            chk("vec_latency", cyc - (c0 + 1), vecs[i].lat);
            chk_pulse("vec", {vecs[i].rs, vecs[i].data});
            chk("vec_extra", pulse_q.size(), 0);
            pulse_q.delete();
        end

        // Back-to-back HELLO with req_valid held.
        stream_buf[0] = 8'h48; stream_buf[1] = 8'h45; stream_buf[2] = 8'h4C;
        stream_buf[3] = 8'h4C; stream_buf[4] = 8'h4F;
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, stream_buf[i]});
        send_stream(5, "hello", lat);
        chk("hello_last_latency", lat, 7);
        chk_stream("hello");

        // Reset in the middle of an E pulse.
        wait_ready("midrst", 100);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (lcd_enable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_pulse_seen", {31'd0, lcd_enable}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_enable", {31'd0, lcd_enable}, 32'd0);
        chk("midrst_data", {24'd0, lcd_data}, 32'd0);
        chk("midrst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("midrst_init_done", {31'd0, init_done}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        do_init("reinit");

        // Sixteen characters fill line 0; then sixteen more fill line 1.
        for (int i = 0; i < 16; i++) begin
            stream_buf[i] = 8'h41 + 8'(i);
            exp_q.push_back({1'b1, stream_buf[i]});
        end
`ifdef LCD_LINE_WRAP_EN
        exp_q.push_back(9'h0C0);
        send_stream(16, "wrap1", lat);
        chk("wrap1_last_latency", lat, 14);
`else
        send_stream(16, "wrap1", lat);
        chk("wrap1_last_latency", lat, 7);
`endif
        chk_stream("wrap1");

        for (int i = 0; i < 16; i++) begin
            stream_buf[i] = 8'h61 + 8'(i);
            exp_q.push_back({1'b1, stream_buf[i]});
        end
`ifdef LCD_LINE_WRAP_EN
        exp_q.push_back(9'h080);
        send_stream(16, "wrap2", lat);
        chk("wrap2_last_latency", lat, 14);
`else
        send_stream(16, "wrap2", lat);
        chk("wrap2_last_latency", lat, 7);
`endif
        chk_stream("wrap2");

        chk("monitor_stable_rw0", mon_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
